// File: rtl/controle_cronometro.sv
// Stopwatch controller: debounced active-low buttons drive a four-state FSM that
// gates a tenth-of-second prescaler and issues clear/freeze controls to the digit counter.
module controle_cronometro #(
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ButtonIniciar,
  input  logic       ButtonPausar,
  input  logic       ButtonParar,
  input  logic       ButtonReset,
  input  logic       fim,
  output logic       tick,
  output logic       zerar,
  output logic       congelar,
  output logic [1:0] estado
);

  // state     | meaning
  // PARADO    | idle, counter cleared or waiting for start
  // CONTANDO  | prescaler running, ticks issued
  // PAUSADO   | prescaler held, resumable
  // CONGELADO | display frozen, only a clear exits

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  localparam int B_INI = 0;
  localparam int B_PAU = 1;
  localparam int B_PAR = 2;
  localparam int B_RST = 3;

  typedef enum logic [1:0] {
    PARADO    = 2'b00,
    CONTANDO  = 2'b01,
    PAUSADO   = 2'b10,
    CONGELADO = 2'b11
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic [3:0]    level;
  logic [3:0]    level_d;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    press;

  state_t        state;
  state_t        state_next;
  logic          clear_evt;
  logic [PW-1:0] presc;

  assign raw = {ButtonReset, ButtonParar, ButtonPausar, ButtonIniciar};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a  <= '1;
      sync_b  <= '1;
      level   <= '1;
      level_d <= '1;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          level[i]   <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the falling edge of the accepted level is an event; release is silent.
  assign press = level_d & ~level;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PARADO;
      zerar <= 1'b0;
      presc <= '0;
    end else begin
      state <= state_next;
      zerar <= clear_evt;
      if (zerar) begin
        presc <= '0;
      end else if (state == CONTANDO) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    clear_evt  = 1'b0;
    if (press[B_RST]) begin
      state_next = PARADO;
      clear_evt  = 1'b1;
    end else begin
      case (state)
        PARADO: begin
          if (press[B_INI]) state_next = CONTANDO;
        end
        CONTANDO: begin
          if (fim || press[B_PAR]) state_next = CONGELADO;
          else if (press[B_PAU])   state_next = PAUSADO;
        end
        PAUSADO: begin
          if (press[B_PAR])      state_next = CONGELADO;
          else if (press[B_INI]) state_next = CONTANDO;
        end
        CONGELADO: begin
          state_next = CONGELADO;
        end
      endcase
    end
  end

  always_comb begin
    tick     = (state == CONTANDO) && (presc == PRESC_LAST);
    congelar = (state == CONGELADO);
  end

  assign estado = state;

endmodule
